// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types, default sizes and the round-robin pick function
//               for the adder round-robin scheduler.
//               - state_e : scheduler FSM state encoding
//               - ALU_N   : default operand/result width
//               - ALU_R   : default requester count
//               - rr_pick : grant index search starting at the RR pointer
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_N      = 32;
    localparam int ALU_R      = 4;
    // Widest requester vector rr_pick can search.
    localparam int RR_MAX     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns the first set bit of valid[0 +: r], searching ptr, ptr+1, ...,
    // r-1, 0, ..., ptr-1. The loop runs from the farthest offset down to
    // offset 0 so that the nearest set bit overwrites any farther one.
    // When nothing is valid the pointer itself is returned.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                   input int ptr,
                                   input int r);
        int pick;
        int idx;
        pick = ptr;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (i < r) begin
                idx = ptr + i;
                if (idx >= r) begin
                    idx = idx - r;
                end
                if (valid[idx[3:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/N_bit_adder.sv
`default_nettype none
// ============================================================================
// Module      : N_bit_adder
// Description : Plain combinational N-bit adder with carry out.
//   a_i     [N-1:0] in  : operand A
//   b_i     [N-1:0] in  : operand B
//   sum_o   [N-1:0] out : (A+B) mod 2^N
//   carry_o         out : carry out of bit N-1
// Revision    : 1.0 - initial release
// ============================================================================
module N_bit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);

    logic [N:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[N-1:0];
    assign carry_o  = full_sum[N];

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin grant selection.
//   valid_i      [R-1:0]   in  : request vector
//   ptr_i        [IDW-1:0] in  : highest-priority index
//   gnt_onehot_o [R-1:0]   out : one-hot grant (zero when nothing valid)
//   gnt_idx_o    [IDW-1:0] out : granted index (meaningful when any_o)
//   any_o                  out : at least one request valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import alu_pkg::*;
#(
    parameter  int R   = 4,
    localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]   valid_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [R-1:0]   gnt_onehot_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           any_o
);

    logic [RR_MAX-1:0] valid_ext;
    int                pick;

    always_comb begin
        valid_ext          = '0;
        valid_ext[R-1:0]   = valid_i;
        pick               = rr_pick(valid_ext, int'(ptr_i), R);
        gnt_idx_o          = IDW'(pick);
        any_o              = |valid_i;
        gnt_onehot_o       = '0;
        if (any_o) begin
            gnt_onehot_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_scheduler
// Description : Shares one N-bit adder between R valid/ready requesters with
//               round-robin grants. Granted operands are registered, added,
//               and the tagged result is held on res_* until accepted.
//   clk        in            : rising-edge clock
//   rst_n      in            : asynchronous active-low reset
//   req_valid  in  [R-1:0]   : per-requester request valid
//   req_ready  out [R-1:0]   : per-requester accept strobe (one-hot or zero)
//   req_a      in  [R*N-1:0] : operand A, requester k at [k*N +: N]
//   req_b      in  [R*N-1:0] : operand B, same packing
//   res_valid  out           : result available (registered, high in DONE)
//   res_ready  in            : result consumer ready
//   res_sum    out [N-1:0]   : (A+B) mod 2^N
//   res_carry  out           : carry out of bit N-1
//   res_id     out [IDW-1:0] : requester that produced the result
//   busy       out           : state is not IDLE
//   op_count   out [CNTW-1:0]: completed result handshakes (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_scheduler
    import alu_pkg::*;
#(
    parameter  int N    = ALU_N,
    parameter  int R    = ALU_R,
    parameter  int CNTW = 16,
    localparam int IDW  = (R > 1) ? $clog2(R) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_sum,
    output logic            res_carry,
    output logic [IDW-1:0]  res_id,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]    op_a_q, op_b_q;
    logic [IDW-1:0]  id_q;
    logic [N-1:0]    res_sum_q;
    logic            res_carry_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_valid_q;
    logic [CNTW-1:0] op_count_q;

    logic [R-1:0]    gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [N-1:0]    sel_a, sel_b;
    logic [N-1:0]    add_sum;
    logic            add_carry;

    logic            load_op;
    logic            load_res;
    logic            complete;

    rr_arbiter #(
        .R (R)
    ) u_arb (
        .valid_i      (req_valid),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .any_o        (gnt_any)
    );

    N_bit_adder #(
        .N (N)
    ) u_adder (
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign sel_a = req_a[int'(gnt_idx)*N +: N];
    assign sel_b = req_b[int'(gnt_idx)*N +: N];

    // Pointer moves one past the granted requester, wrapping after R-1.
    assign ptr_d = (gnt_idx == IDW'(R - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load_op   = 1'b0;
        load_res  = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt_onehot;
                    load_op   = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                load_res = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            // Registered so res_valid is a clean flop output tracking DONE.
            res_valid_q <= (state_d == DONE);
            if (load_op) begin
                op_a_q <= sel_a;
                op_b_q <= sel_b;
                id_q   <= gnt_idx;
                ptr_q  <= ptr_d;
            end
            if (load_res) begin
                res_sum_q   <= add_sum;
                res_carry_q <= add_carry;
                res_id_q    <= id_q;
            end
            if (complete) begin
                op_count_q <= op_count_q + CNTW'(1);
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_carry = res_carry_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rr_scheduler
// Description : Directed self-checking bench for adder_rr_scheduler (R=4,
//               N=32). Inputs change on the falling edge; outputs are
//               sampled 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_scheduler;

    localparam int N    = 32;
    localparam int R    = 4;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*N-1:0]  req_a;
    logic [R*N-1:0]  req_b;
    logic            res_valid;
    logic            res_ready;
    logic [N-1:0]    res_sum;
    logic            res_carry;
    logic [1:0]      res_id;
    logic            busy;
    logic [CNTW-1:0] op_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    adder_rr_scheduler #(.N(N), .R(R), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if ({res_sum, res_carry, res_id} !== '0) begin errors++; $display("FAIL reset_res_fields: got %h/%b/%0d want 0", res_sum, res_carry, res_id); end
        checks++; if (busy !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL reset_busy_count: got %b/%0d want 0/0", busy, op_count); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got %b/%b want 0/0", res_valid, busy); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        set_ops(2, 32'h0000_0005, 32'h0000_0003);
        @(negedge clk); req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_calc: got valid=%b busy=%b want 0/1", res_valid, busy); end
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
        checks++; if (res_sum !== 32'h8 || res_carry !== 1'b0 || res_id !== 2'd2) begin errors++; $display("FAIL single_result: got %h/%b/%0d want 8/0/2", res_sum, res_carry, res_id); end
        @(negedge clk); #1;
        exp_cnt++;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'(exp_cnt)) begin errors++; $display("FAIL single_complete: got valid=%b busy=%b cnt=%0d want 0/0/%0d", res_valid, busy, op_count, exp_cnt); end
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk); req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ovf_grant: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_sum !== 32'h0 || res_carry !== 1'b1 || res_id !== 2'd0) begin errors++; $display("FAIL ovf_result: got v=%b %h/%b/%0d want 1 0/1/0", res_valid, res_sum, res_carry, res_id); end
        @(negedge clk); exp_cnt++;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] want_sum;
        int bad;
        want_sum = 32'h2345_6789;
        res_ready = 1'b0;
        set_ops(1, 32'h1234_5678, 32'h1111_1111);
        set_ops(0, 32'h0000_00AA, 32'h0000_0001);
        @(negedge clk); req_valid = 4'b0010; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        // Requester 0 waits through the stall and then gives up unserved.
        @(negedge clk); req_valid = 4'b0001;
        @(negedge clk); #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_sum !== want_sum || res_id !== 2'd1 || req_ready !== 4'b0000 || op_count !== 16'(exp_cnt)) begin
                bad++;
                if (bad == 1) $display("FAIL bp_hold cycle %0d: got v=%b sum=%h id=%0d rdy=%b cnt=%0d want 1/%h/1/0000/%0d", i, res_valid, res_sum, res_id, req_ready, op_count, want_sum, exp_cnt);
            end
            @(negedge clk); #1;
        end
        checks++; if (bad != 0) errors++;
        res_ready = 1'b1;
        @(negedge clk); req_valid = '0; #1;
        exp_cnt++;
        checks++; if (res_valid !== 1'b0 || op_count !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_release: got v=%b cnt=%0d want 0/%0d", res_valid, op_count, exp_cnt); end
        @(negedge clk); #1;
        checks++; if (op_count !== 16'(exp_cnt) || busy !== 1'b0) begin errors++; $display("FAIL bp_single_completion: got cnt=%0d busy=%b want %0d/0", op_count, busy, exp_cnt); end
    endtask

    task automatic test_ptr_wrap();
        res_ready = 1'b1;
        set_ops(3, 32'h8000_0000, 32'h8000_0000);
        @(negedge clk); req_valid = 4'b1000; #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (res_sum !== 32'h0 || res_carry !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL wrap_result3: got %h/%b/%0d want 0/1/3", res_sum, res_carry, res_id); end
        exp_cnt++;
        set_ops(0, 32'd10, 32'd20);
        set_ops(3, 32'hFFFF_FFFE, 32'h0000_0003);
        @(negedge clk); req_valid = 4'b1001; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = 4'b1000; #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wrap_calc_ready: got %b want 0000", req_ready); end
        @(negedge clk); #1;
        checks++; if (res_sum !== 32'd30 || res_carry !== 1'b0 || res_id !== 2'd0) begin errors++; $display("FAIL wrap_result0: got %h/%b/%0d want 1e/0/0", res_sum, res_carry, res_id); end
        exp_cnt++;
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3b: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (res_sum !== 32'h1 || res_carry !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL wrap_result3b: got %h/%b/%0d want 1/1/3", res_sum, res_carry, res_id); end
        exp_cnt++;
        @(negedge clk); #1;
        checks++; if (op_count !== 16'(exp_cnt)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic [R-1:0] want_rdy;
        logic         want_v;
        int           bad;
        int           k;
        res_ready = 1'b1;
        for (int j = 0; j < R; j++) set_ops(j, 32'(32'h100 * (j + 1)), 32'(j));
        bad = 0;
        @(negedge clk); req_valid = 4'b1111;
        for (int i = 0; i < 18; i++) begin
            #1;
            k = i / 3;
            want_rdy = (i % 3 == 0) ? 4'(1 << order[k]) : 4'b0000;
            want_v = (i % 3 == 2);
            if (req_ready !== want_rdy || res_valid !== want_v) begin
                bad++;
                $display("FAIL rr_cycle %0d: got rdy=%b v=%b want %b/%b", i, req_ready, res_valid, want_rdy, want_v);
            end
            if (want_v && (res_id !== 2'(order[k]) || res_sum !== 32'(32'h100 * (order[k] + 1) + order[k]))) begin
                bad++;
                $display("FAIL rr_result %0d: got id=%0d sum=%h want %0d", k, res_id, res_sum, order[k]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++; if (bad != 0) errors++;
        exp_cnt += 6;
        #1;
        checks++; if (op_count !== 16'(exp_cnt) || busy !== 1'b0) begin errors++; $display("FAIL rr_count: got %0d busy=%b want %0d/0", op_count, busy, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        set_ops(2, 32'd7, 32'd9);
        @(negedge clk); req_valid = 4'b0100;
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_sum !== 32'd16) begin errors++; $display("FAIL rstmid_pre: got v=%b sum=%h want 1/10", res_valid, res_sum); end
        #2; rst_n = 1'b0; #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL rstmid_async: got v=%b busy=%b cnt=%0d want 0/0/0", res_valid, busy, op_count); end
        exp_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse: got v=%b busy=%b want 0/0", res_valid, busy); end
        // Requesters 1 and 3: pointer cleared to 0 picks 1; a stale pointer of 3 would pick 3.
        res_ready = 1'b1;
        set_ops(1, 32'hDEAD_0000, 32'h0000_BEEF);
        set_ops(3, 32'h7FFF_FFFF, 32'h0000_0001);
        req_valid = 4'b1010; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant1: got %b want 0010", req_ready); end
        @(negedge clk); req_valid = 4'b1000;
        @(negedge clk); #1;
        checks++; if (res_sum !== 32'hDEAD_BEEF || res_carry !== 1'b0 || res_id !== 2'd1) begin errors++; $display("FAIL rstmid_result1: got %h/%b/%0d want deadbeef/0/1", res_sum, res_carry, res_id); end
        exp_cnt++;
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rstmid_grant3: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (res_sum !== 32'h8000_0000 || res_carry !== 1'b0 || res_id !== 2'd3) begin errors++; $display("FAIL rstmid_result3: got %h/%b/%0d want 80000000/0/3", res_sum, res_carry, res_id); end
        exp_cnt++;
        @(negedge clk); #1;
        checks++; if (op_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_backpressure();
        test_ptr_wrap();
        test_round_robin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
